// File: rtl/fetch_stage.sv
// In-order instruction fetch: credit-limited request issue, response FIFO
// toward decode, and redirect handling that drops stale in-flight responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, HALT} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  state_t                 state;
  logic [31:0]            pc;
  logic [CW-1:0]          inflight, inflight_nxt, drop, fifo_cnt;
  logic [CW:0]            occ;
  entry_t [DEPTH-1:0]     fifo_q;
  logic [DEPTH-1:0][31:0] rpc_q;
  logic [PW-1:0]          fifo_wr, fifo_rd, rpc_wr, rpc_rd;
  logic                   req_fire, push, pop;
  entry_t                 head;
  logic                   unused_redirect_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Buffered entries still hold a credit, so the FIFO can never overflow.
  assign occ            = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign imem_req_valid = ~rst & (state == FETCH) & ~redirect_valid & (occ < CREDITS);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign push = imem_resp_valid & (drop == '0) & ~redirect_valid;
  assign pop  = inst_valid & inst_ready;

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire)        inflight_nxt = inflight_nxt + CW'(1);
    if (imem_resp_valid) inflight_nxt = inflight_nxt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      fifo_cnt <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      rpc_wr   <= '0;
      rpc_rd   <= '0;
      fifo_q   <= '0;
      rpc_q    <= '0;
    end else begin
      inflight <= inflight_nxt;
      // Request-PC queue tracks every outstanding request, stale or not.
      if (req_fire) begin
        rpc_q[rpc_wr] <= pc;
        rpc_wr        <= ptr_inc(rpc_wr);
      end
      if (imem_resp_valid) rpc_rd <= ptr_inc(rpc_rd);

      if (redirect_valid) begin
        state    <= FETCH;
        pc       <= {redirect_pc[31:2], 2'b00};
        drop     <= inflight_nxt;
        fifo_cnt <= '0;
        fifo_rd  <= fifo_wr;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_resp_valid && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          fifo_q[fifo_wr].data <= imem_resp_err ? 32'h0 : imem_resp_data;
          fifo_q[fifo_wr].pc   <= rpc_q[rpc_rd];
          fifo_q[fifo_wr].err  <= imem_resp_err;
          fifo_wr              <= ptr_inc(fifo_wr);
          if (imem_resp_err && state == FETCH) state <= HALT;
        end
        if (pop) fifo_rd <= ptr_inc(fifo_rd);
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
          2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Empty FIFO presents zeros so flushed storage never leaks to decode.
  assign head       = fifo_q[fifo_rd];
  assign inst_valid = (fifo_cnt != '0);
  assign inst       = inst_valid ? head.data : 32'h0;
  assign inst_pc    = inst_valid ? head.pc   : 32'h0;
  assign inst_fault = inst_valid & head.err;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that feeds the decode stage with a 32-bit instruction word plus its PC.
- Holds the PC and issues in-order word reads to instruction memory over a valid/ready request channel, then accepts in-order responses.
- Buffers responses in a small FIFO and presents them to decode over a valid/ready channel.
- Handles redirects from branch/jump resolution by discarding stale in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, entries in the output FIFO; also the maximum number of requests in flight plus entries buffered (credit limit); legal values 2..8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_resp_valid  in  1  in-order response valid; memory never stalls responses.
- imem_resp_data  in  32  instruction word.
- imem_resp_err  in  1  access fault for this response.
- redirect_valid  in  1  redirect fetch to redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  FIFO head valid toward decode.
- inst_ready  in  1  decode consumes the head.
- inst  out  32  instruction word; 32'h0000_0000 when inst_fault=1.
- inst_pc  out  32  PC of the head entry.
- inst_fault  out  1  head entry carries an access fault.

Behaviour:
- Reset (async assert): pc=RESET_PC, state=FETCH, FIFO empty, inflight=0, drop=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0. Reset asserted mid-operation discards everything, including in-flight requests; memory is reset by the same signal.
- Counters:
  - inflight = accepted requests whose response has not returned.
  - drop = the subset of those that are stale.
  - fifo_cnt = buffered entries.
- Request issue: imem_req_valid = (state==FETCH) && !redirect_valid && (inflight + fifo_cnt < DEPTH).
  - imem_req_addr = pc.
  - Handshake = valid && ready.
  - On handshake: pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), inflight += 1.
  - Memory samples the address only on handshake; valid may drop without a handshake when a redirect arrives.
- Response: on imem_resp_valid, inflight -= 1.
  - If drop>0: drop -= 1 and the data is discarded.
  - Otherwise push {data, pc_of_request, err} into the FIFO; the PC is tracked in a parallel request-PC queue.
  - The credit rule guarantees the FIFO never overflows.
- Latency: a response pushed in cycle N makes inst_valid=1 in cycle N+1 (registered FIFO, no bypass). With single-cycle memory, the first inst_valid appears 2 cycles after the first request handshake.
- Output: inst/inst_pc/inst_fault reflect the FIFO head. The head pops on inst_valid && inst_ready. Outputs stay stable while valid && !ready.
- States:
  - FETCH: normal issue. An accepted error response moves to HALT when it is pushed.
  - HALT: no new requests; existing responses are still accepted and buffered.
  - Any redirect: go to FETCH.
- Redirect (redirect_valid=1 in cycle N):
  - FIFO flushed; a same-cycle pop is still counted as consumed.
  - drop = inflight_next, which includes any request whose handshake would occur in N; no request handshake occurs in N since valid is forced low.
  - Any response arriving in N is discarded.
  - pc = {redirect_pc[31:2], 2'b00}.
  - First new request is in cycle N+1.
- Back-to-back redirects: each one re-flushes; drop is recomputed from the current inflight.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.

Test Plan:
- Reset release, RESET_PC=0x100, memory ready always, 1-cycle response returning addr^0xA5A5_0000, inst_ready=1 -> requests 0x100, 0x104, 0x108, ... on consecutive cycles; inst_pc 0x100 appears 2 cycles after the first handshake with inst=0xA5A5_0100; one instruction per cycle thereafter.
- inst_ready=0 for 10 cycles, DEPTH=2 -> at most 2 requests outstanding plus buffered, then imem_req_valid=0; inst/inst_pc stay stable; on release the entries drain in order 0x100, 0x104 and fetch resumes at 0x108.
- Two requests in flight (0x200, 0x204), redirect to 0x403 -> both responses discarded, FIFO empty, next request addr 0x400, first delivered inst_pc=0x400.
- Response for 0x300 with imem_resp_err=1 -> entry delivered with inst_fault=1, inst=0, inst_pc=0x300; no new requests until redirect to 0x80, then fetch at 0x80.
- redirect_pc=0xFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000.
- rst asserted asynchronously mid-stream with the FIFO full -> all outputs zero immediately; after release, fetch restarts at RESET_PC with no stale instructions.
